// File: rtl/xor_pkg.sv
// rtl/xor_pkg.sv - shared state type and counter-width helper for the XOR frame checksum
package xor_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Bits needed to hold 0..max_len inclusive.
  function automatic int cnt_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/xor_word.sv
// rtl/xor_word.sv - combinational WIDTH-bit bitwise XOR
module xor_word #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = a_i ^ b_i;

endmodule

// File: rtl/xor_frame_checksum.sv
// rtl/xor_frame_checksum.sv - folds a frame of words with XOR and holds the result until consumed
module xor_frame_checksum
  import xor_pkg::*;
#(
  parameter int  WIDTH   = 8,
  parameter int  MAX_LEN = 16,
  localparam int CNT_W   = cnt_width(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_len,
  output logic             out_parity,
  output logic             out_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] olen_q, olen_d;
  logic             par_q, par_d;
  logic             oerr_q, oerr_d;

  logic [WIDTH-1:0] acc_x;
  logic             len_at_max;
  logic [CNT_W-1:0] len_inc;
  logic             err_inc;

  xor_word #(.WIDTH(WIDTH)) u_xor_word (
    .a_i (acc_q),
    .b_i (in_data),
    .y_o (acc_x)
  );

  // The count saturates; a word arriving at the cap marks the frame overlong.
  assign len_at_max = (len_q == CNT_W'(MAX_LEN));
  assign len_inc    = len_at_max ? len_q : len_q + CNT_W'(1);
  assign err_inc    = err_q | len_at_max;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    len_d   = len_q;
    err_d   = err_q;
    sum_d   = sum_q;
    olen_d  = olen_q;
    par_d   = par_q;
    oerr_d  = oerr_q;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          if (in_last) begin
            sum_d   = acc_x;
            olen_d  = len_inc;
            oerr_d  = err_inc;
            par_d   = ^acc_x;
            acc_d   = '0;
            len_d   = '0;
            err_d   = 1'b0;
            state_d = HOLD;
          end else begin
            acc_d = acc_x;
            len_d = len_inc;
            err_d = err_inc;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      sum_q   <= '0;
      olen_q  <= '0;
      par_q   <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      olen_q  <= olen_d;
      par_q   <= par_d;
      oerr_q  <= oerr_d;
    end
  end

  assign in_ready   = (state_q == ACC);
  assign out_valid  = (state_q == HOLD);
  assign out_sum    = sum_q;
  assign out_len    = olen_q;
  assign out_parity = par_q;
  assign out_err    = oerr_q;

endmodule

// File: tb/tb_xor_frame_checksum.sv
// tb/tb_xor_frame_checksum.sv - scoreboard bench for xor_frame_checksum
module tb_xor_frame_checksum;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic [2:0] out_len;
  logic       out_parity;
  logic       out_err;

  typedef struct packed {
    logic [7:0] sum;
    logic [2:0] len;
    logic       par;
    logic       err;
  } res_t;

  res_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  xor_frame_checksum #(.WIDTH(8), .MAX_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_len    (out_len),
    .out_parity (out_parity),
    .out_err    (out_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_res(input logic [7:0] s, input logic [2:0] l, input logic p, input logic e);
    res_t r;
    r.sum = s; r.len = l; r.par = p; r.err = e;
    exp_q.push_back(r);
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic after_result();
    chk("valid_latency", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    chk("valid_pulse_end", 32'(out_valid), 32'd0);
    chk("ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  // Monitor: pop the expected result whenever the DUT hands one off.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(out_sum), 32'hFFFF_FFFF);
        end else begin
          r = exp_q.pop_front();
          chk("out_sum", 32'(out_sum), 32'(r.sum));
          chk("out_len", 32'(out_len), 32'(r.len));
          chk("out_parity", 32'(out_parity), 32'(r.par));
          chk("out_err", 32'(out_err), 32'(r.err));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_len", 32'(out_len), 32'd0);
    chk("rst_out_parity", 32'(out_parity), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // three-word frame
    expect_res(8'h00, 3'd3, 1'b0, 1'b0);
    send(8'h0F, 1'b0); send(8'hF0, 1'b0); send(8'hFF, 1'b1);
    after_result();

    // single-word frame
    expect_res(8'hA5, 3'd1, 1'b0, 1'b0);
    send(8'hA5, 1'b1);
    after_result();

    // back-pressure: result held, new word refused
    out_ready = 1'b0;
    expect_res(8'h03, 3'd2, 1'b0, 1'b0);
    send(8'h01, 1'b0); send(8'h02, 1'b1);
    chk("hold_valid_rise", 32'(out_valid), 32'd1);
    in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_sum", 32'(out_sum), 32'h03);
      chk("hold_out_parity", 32'(out_parity), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    chk("hold_release_valid", 32'(out_valid), 32'd0);
    chk("hold_release_ready", 32'(in_ready), 32'd1);

    // overlong frame, then a clean one
    expect_res(8'h00, 3'd4, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send(8'h01, 1'b0);
    send(8'h01, 1'b1);
    after_result();
    expect_res(8'h80, 3'd1, 1'b1, 1'b0);
    send(8'h80, 1'b1);
    after_result();

    // asynchronous reset mid-frame
    send(8'h11, 1'b0); send(8'h22, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_sum", 32'(out_sum), 32'd0);
    chk("arst_out_len", 32'(out_len), 32'd0);
    chk("arst_out_parity", 32'(out_parity), 32'd0);
    chk("arst_out_err", 32'(out_err), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    expect_res(8'h3C, 3'd1, 1'b0, 1'b0);
    send(8'h3C, 1'b1);
    after_result();

    // back-to-back frames
    expect_res(8'hFF, 3'd2, 1'b0, 1'b0);
    expect_res(8'hFF, 3'd1, 1'b0, 1'b0);
    send(8'hAA, 1'b0); send(8'h55, 1'b1);
    chk("b2b_valid1", 32'(out_valid), 32'd1);
    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
    @(posedge clk); #1;
    chk("b2b_gap_valid", 32'(out_valid), 32'd0);
    chk("b2b_gap_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("b2b_valid2", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    chk("b2b_valid2_end", 32'(out_valid), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_frame_checksum.md
# xor_frame_checksum

Streaming XOR checksum unit: the parametrised, sequential successor to the team's single-bit XOR gate. It accepts a frame of WIDTH-bit words over a valid/ready handshake and folds them with bitwise XOR. On the last word it presents the checksum, word count, parity and an overflow flag on a registered valid/ready output. It sits between a word source (test driver or upstream framer) and any consumer that checks frame integrity.

## Interface
- WIDTH, 8: data word width in bits (≥1).
- MAX_LEN, 16: maximum words per frame before the overflow flag is set (≥1).
- CNT_W, $clog2(MAX_LEN+1): width of the length counter; derived, never overridden.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input word present.
- in_ready  out  1  unit can accept a word.
- in_data  in  WIDTH  input word.
- in_last  in  1  marks the final word of the frame.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  XOR of all words in the frame.
- out_len  out  CNT_W  accepted word count, saturating at MAX_LEN.
- out_parity  out  1  XOR-reduce of out_sum.
- out_err  out  1  frame had more than MAX_LEN words.

## Operation
- FSM has two states:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Reset state is ACC. Reset values:
  - acc=0, len=0, err=0.
  - out_sum=0, out_len=0, out_parity=0, out_err=0, out_valid=0.
  - in_ready=1 once rst deasserts.
- An input word is accepted when in_valid && in_ready.
- On a non-last accept:
  - acc <= acc ^ in_data.
  - len <= len+1 if len<MAX_LEN; otherwise len holds at MAX_LEN and err <= 1.
- On a last accept:
  - out_sum <= acc ^ in_data; out_len and out_err take the same update as above.
  - out_parity <= ^(acc ^ in_data).
  - acc, len and err clear to 0; state goes to HOLD.
- In HOLD, outputs stay stable until out_valid && out_ready, then the FSM returns to ACC.
- Output registers are not cleared on handshake; they keep the last result.
- A single-word frame (in_last on the first word) gives out_sum=in_data and out_len=1.
- Overflow: err sets when a word is accepted while len==MAX_LEN. The XOR still includes every word.
- in_data and in_last are ignored whenever in_ready=0.
- Reset mid-frame or during HOLD: the partial frame and any pending result are discarded and all registers return to their reset values.

## Timing
- out_valid rises on the first clock edge after the last-word accept, i.e. one cycle of latency.
- in_ready is a pure decode of state, with no combinational path from out_ready.
- After a handshake, in_ready returns to 1 in the next cycle, so there is one bubble cycle per frame.
- Peak throughput is one frame per (len+1) cycles.
- in_ready, in_valid, in_last and out_ready are all sampled only at rising edges.

## Structure
- Shared package xor_pkg holds:
  - the state typedef (ACC, HOLD);
  - a clog2-based helper for CNT_W.
- Sub-module xor_word: purely combinational WIDTH-bit bitwise XOR (a ^ b), the parametrised form of the single-bit gate. It is instantiated once for the accumulator datapath.
- Everything else stays in xor_frame_checksum.

## Test plan
All scenarios use WIDTH=8 and MAX_LEN=4.
- Three-word frame 0x0F, 0xF0, 0xFF (last on 0xFF), out_ready=1 -> one cycle later out_valid=1 with out_sum=0x00, out_len=3, out_parity=0, out_err=0.
- Single-word frame 0xA5 with last -> out_sum=0xA5, out_len=1, out_parity=0, out_err=0; in_ready=1 the cycle after the handshake.
- Frame 0x01, 0x02 (last), out_ready held low 5 cycles -> out_valid=1 and in_ready=0 for all 5 cycles with out_sum=0x03 and out_parity=0 stable; a new in_valid is not accepted; after out_ready=1, ACC resumes.
- Overlong frame of six 0x01 words, last on the 6th -> out_sum=0x00, out_len=4, out_err=1; the next 1-word frame 0x80 -> out_err=0, out_len=1, out_parity=1.
- Assert rst asynchronously after two words 0x11, 0x22 -> all outputs 0 immediately; the next frame 0x3C (last) -> out_sum=0x3C, out_len=1 (no residue).
- Two back-to-back frames {0xAA, 0x55 last} then {0xFF last}, out_ready=1 -> results 0xFF (len 2, parity 0) and 0xFF (len 1), each out_valid pulse exactly one cycle, with one-cycle gap.
